// File: rtl/sign_ext_if.sv
// sign_ext_if: immediate-extender bus bundle; the testbench drives the extender through it.
interface sign_ext_if #(
   parameter int OUT_WIDTH = 32,
   parameter int IN_WIDTH  = 16
);
   logic [IN_WIDTH-1:0]  in;
   logic [OUT_WIDTH-1:0] out;
   logic                 in_valid;
   logic [OUT_WIDTH-1:0] out_q;
   logic                 out_q_valid;
   logic [1:0]           mode;
   modport master (output in, in_valid, mode, input out, out_q, out_q_valid);
   modport slave  (input in, in_valid, mode, output out, out_q, out_q_valid);
endinterface

// File: rtl/sign_ext.sv
// sign_ext: widens an immediate for the datapath, combinational plus a registered copy.
// Define SIGNEXT_MODE_EN to add the mode port (zero-extend, upper-place, branch-shift).
module sign_ext #(
   parameter int OUT_WIDTH = 32,
   parameter int IN_WIDTH  = 16
) (
   input  logic [IN_WIDTH-1:0]  in,
   output logic [OUT_WIDTH-1:0] out,
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic [OUT_WIDTH-1:0] out_q,
   output logic                 out_q_valid
`ifdef SIGNEXT_MODE_EN
   ,
   input  logic [1:0]           mode
`endif
);
   logic [OUT_WIDTH-1:0] sext;
   logic [OUT_WIDTH-1:0] out_d;
   logic                 valid_q;
   logic                 valid_d;
   // Width casts of a signed/unsigned operand avoid zero-count replication at equal widths.
   assign sext = OUT_WIDTH'($signed(in));
`ifdef SIGNEXT_MODE_EN
   logic [OUT_WIDTH-1:0] zext;
   assign zext = OUT_WIDTH'(in);
   always_comb begin
      out = sext;
      case (mode)
         2'b01:   out = zext;
         2'b10:   out = zext << (OUT_WIDTH - IN_WIDTH);
         2'b11:   out = sext << 2;
         default: out = sext;
      endcase
   end
`else
   assign out = sext;
`endif
   always_comb begin
      out_d   = in_valid ? out : out_q;
      valid_d = in_valid;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         out_q   <= out_d;
         valid_q <= valid_d;
      end
   end
   assign out_q_valid = valid_q;
endmodule

// File: tb/tb_sign_ext.sv
// tb_sign_ext: directed checks of combinational extension, registered copy and async reset.
module tb_sign_ext;
   logic clk = 1'b0;
   logic run = 1'b0;
   logic reset = 1'b0;
   int   tests = 0;
   int   fails = 0;
   sign_ext_if #(32, 16) bus ();
   sign_ext_if #(16, 16) bus16 ();
   sign_ext #(32, 16) dut (
      .in(bus.in), .out(bus.out), .clk(clk), .reset(reset), .in_valid(bus.in_valid),
      .out_q(bus.out_q), .out_q_valid(bus.out_q_valid)
`ifdef SIGNEXT_MODE_EN
      , .mode(bus.mode)
`endif
   );
   sign_ext #(16, 16) dut16 (
      .in(bus16.in), .out(bus16.out), .clk(clk), .reset(reset), .in_valid(bus16.in_valid),
      .out_q(bus16.out_q), .out_q_valid(bus16.out_q_valid)
`ifdef SIGNEXT_MODE_EN
      , .mode(bus16.mode)
`endif
   );
   always begin
      #5;
      clk = run ? ~clk : clk;
   end
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   initial begin
      bus.in = 16'h0001;
      bus.in_valid = 1'b0;
      bus.mode = 2'b00;
      bus16.in = 16'hABCD;
      bus16.in_valid = 1'b0;
      bus16.mode = 2'b00;
      #1 check("sext_1", bus.out, 32'h00000001);
      bus.in = 16'hFFFF;
      #1 check("sext_m1", bus.out, 32'hFFFFFFFF);
      bus.in = 16'h8000;
      #1 check("sext_8000", bus.out, 32'hFFFF8000);
      bus.in = 16'h7FFF;
      #1 check("sext_7fff", bus.out, 32'h00007FFF);
      check("equal_width", {16'h0, bus16.out}, 32'h0000ABCD);
`ifdef SIGNEXT_MODE_EN
      bus.in = 16'hFFFF;
      bus.mode = 2'b01;
      #1 check("mode_zext", bus.out, 32'h0000FFFF);
      bus.mode = 2'b10;
      #1 check("mode_upper", bus.out, 32'hFFFF0000);
      bus.mode = 2'b11;
      #1 check("mode_branch", bus.out, 32'hFFFFFFFC);
      bus16.mode = 2'b11;
      #1 check("eq_branch", {16'h0, bus16.out}, 32'h0000AF34);
      bus.mode = 2'b00;
      bus16.mode = 2'b00;
`endif
      reset = 1'b1;
      #1 check("rst_out_q", bus.out_q, 32'h0);
      check("rst_valid", {31'h0, bus.out_q_valid}, 32'h0);
      reset = 1'b0;
      run = 1'b1;
      @(negedge clk);
      bus.in = 16'h8001;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 check("cap_out_q", bus.out_q, 32'hFFFF8001);
      check("cap_valid", {31'h0, bus.out_q_valid}, 32'h1);
      @(negedge clk);
      bus.in = 16'h1234;
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1 check("hold_out_q", bus.out_q, 32'hFFFF8001);
      check("hold_valid", {31'h0, bus.out_q_valid}, 32'h0);
      bus.in_valid = 1'b1;
      #1 reset = 1'b1;
      #1 check("mid_rst_out_q", bus.out_q, 32'h0);
      check("mid_rst_valid", {31'h0, bus.out_q_valid}, 32'h0);
      check("mid_rst_out", bus.out, 32'h00001234);
      @(posedge clk);
      #1 check("rst_held", bus.out_q, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      bus.in = 16'h7FFF;
      @(posedge clk);
      #1 check("post_rst_cap", bus.out_q, 32'h00007FFF);
      check("post_rst_valid", {31'h0, bus.out_q_valid}, 32'h1);
      run = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/sign_ext.md
# sign_ext

Parameterised immediate extender for the single-cycle/pipelined CPU datapath. It widens an IN_WIDTH-bit immediate field to OUT_WIDTH bits for the ALU and the branch-offset adder. The main output is purely combinational and also has a registered copy for pipelined use. In the default build the block always sign-extends; an optional mode port adds zero-extend, upper-place and branch-shift variants.

## Interface
- OUT_WIDTH, default 32: width of the extended result. This is the first (positional) parameter.
- IN_WIDTH, default 16: width of the immediate input. Required: OUT_WIDTH >= IN_WIDTH.
- clk  input  1  rising-edge clock; used only by the registered outputs.
- reset  input  1  asynchronous, active-high; clears the registered outputs.
- in  input  IN_WIDTH  immediate field to extend.
- out  output  OUT_WIDTH  combinational extended value.
- in_valid  input  1  qualifies `in` for capture into the register.
- out_q  output  OUT_WIDTH  registered copy of `out`.
- out_q_valid  output  1  registered copy of `in_valid`.
- mode  input  2  extension mode. Present only when SIGNEXT_MODE_EN is defined.
- Port declaration order is fixed: in, out, clk, reset, in_valid, out_q, out_q_valid, mode. Positional instantiation `(in, out)` must compile and work.

## Operation
- Mode 00, sign-extend: out = {(OUT_WIDTH-IN_WIDTH) copies of in[IN_WIDTH-1], in}.
- Mode 01, zero-extend: out = {zeros, in}.
- Mode 10, upper-place: out = in << (OUT_WIDTH-IN_WIDTH). Low bits are zero; no sign fill.
- Mode 11, branch offset: the sign-extended value shifted left by 2. Bits shifted past OUT_WIDTH-1 are discarded.
- When OUT_WIDTH == IN_WIDTH:
  - modes 00, 01 and 10 pass `in` through unchanged;
  - mode 11 gives in << 2, truncated.
- Any mode value containing X/Z is treated as 00.
- Unconnected in_valid and clk must not affect `out`.
- No internal state other than the out_q and out_q_valid registers.

## Timing
- `out`: zero latency, combinational from `in` and `mode`. There is no clock dependency. `out` must settle without any clock edge.
- On each clk rising edge, out_q_valid <= in_valid.
- On a clk rising edge with in_valid = 1: out_q <= out.
- On a clk rising edge with in_valid = 0: out_q holds its value.
- reset asserted, at any time and independent of clk:
  - out_q = 0 and out_q_valid = 0 immediately;
  - both stay at 0 while reset is high;
  - `out` is unaffected.
- Reset deasserted: the first capture happens on the next clk rising edge.
- Reset asserted in the same instant as a capture edge: reset wins, and the registered outputs are 0.
- Latency `in` to `out_q`: 1 cycle.

## Configuration
- SIGNEXT_MODE_EN defined:
  - the `mode` port exists;
  - all four modes are implemented as described in Operation.
- SIGNEXT_MODE_EN undefined:
  - the `mode` port is absent;
  - the block is hard-wired to mode 00 (sign-extend);
  - the mode muxes are not synthesised.
- The default build leaves SIGNEXT_MODE_EN undefined.

## Test plan
- Default build, OUT_WIDTH=32, in=16'h0001 → out=32'h00000001 with no clock running. Then in=16'hFFFF (-1) → out=32'hFFFFFFFF.
- in=16'h8000 → out=32'hFFFF8000. in=16'h7FFF → out=32'h00007FFF (sign-bit boundary).
- SIGNEXT_MODE_EN defined, in=16'hFFFF:
  - mode 01 → 32'h0000FFFF;
  - mode 10 → 32'hFFFF0000;
  - mode 11 → 32'hFFFFFFFC.
- Registered path: reset pulse gives out_q=0 and out_q_valid=0. Then in_valid=1, in=16'h8001 → after 1 edge, out_q=32'hFFFF8001 and out_q_valid=1. Then in_valid=0 with new `in` → out_q holds.
- Reset mid-operation: assert reset between clock edges while out_q is non-zero → out_q=0 immediately, before the next edge; out stays unchanged.
- OUT_WIDTH=16, IN_WIDTH=16: in=16'hABCD → out=16'hABCD.
